stopwatch_core: RTL and testbench

Stopwatch (跑表) time-keeping stage. It sits directly downstream of the clock divider and consumes its 100 Hz square-wave output. Maintains a BCD minutes:seconds.centiseconds count with start/stop, lap-freeze and clear control. Its BCD digits feed the display scan/refresh stage.

---
 rtl/stopwatch_core_if.sv | 37 +++
 rtl/stopwatch_core.sv | 132 +++++++++++++
 tb/tb_stopwatch_core.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_core_if.sv
// ---------------------------------------------------------------------------
// stopwatch_core_if
// Groups the stopwatch control inputs and display/status outputs.
//   f100Hz      : 100 Hz square wave from the divider (clk domain)
//   start_stop  : one-cycle pulse, toggles run/pause
//   lap         : one-cycle pulse, toggles display freeze while running
//   clr         : one-cycle pulse, zeroes the stopwatch
//   cs_bcd      : displayed centiseconds, {tens,units} BCD
//   sec_bcd     : displayed seconds, {tens,units} BCD
//   min_bcd     : displayed minutes, {tens,units} BCD
//   running     : high in RUN or LAP
//   lap_active  : high in LAP
//   ovf         : sticky overflow flag
// master = the side that drives the controls, slave = the stopwatch core.
// ---------------------------------------------------------------------------
interface stopwatch_core_if;
    logic       f100Hz;
    logic       start_stop;
    logic       lap;
    logic       clr;
    logic [7:0] cs_bcd;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic       running;
    logic       lap_active;
    logic       ovf;

    modport master (
        output f100Hz, start_stop, lap, clr,
        input  cs_bcd, sec_bcd, min_bcd, running, lap_active, ovf
    );

    modport slave (
        input  f100Hz, start_stop, lap, clr,
        output cs_bcd, sec_bcd, min_bcd, running, lap_active, ovf
    );
endinterface

// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
// BCD minutes:seconds.centiseconds stopwatch driven by the 100 Hz divider
// output, with start/stop, lap-freeze and clear control.
//   clk : system clock
//   rst : synchronous reset, active-high
//   sw  : stopwatch_core_if.slave (controls in, BCD display and status out)
// Parameters:
//   MIN_LIMIT   : highest minute value (0..99) before overflow
//   HOLD_ON_OVF : 1 = saturate at MIN_LIMIT:59.99 and pause on overflow,
//                 0 = wrap to 00:00.00 and keep running
// ---------------------------------------------------------------------------
module stopwatch_core #(
    parameter int MIN_LIMIT   = 59,
    parameter bit HOLD_ON_OVF = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    stopwatch_core_if.slave   sw
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    localparam logic [7:0] MIN_LIMIT_BCD = {4'(MIN_LIMIT / 10), 4'(MIN_LIMIT % 10)};

    state_t           state_reg, state_next;
    logic             f_d_reg;
    logic [5:0][3:0]  cnt_reg, cnt_next, cnt_inc;    // digit 0 = cs units ... 5 = min tens
    logic [5:0][3:0]  disp_reg, disp_next;
    logic             running_reg, lap_active_reg;
    logic             ovf_reg, ovf_next;
    logic             tick, adv, at_limit, ovf_evt;
    logic [5:0]       carry;

    // Rising edge of the divider output; same clock domain, so no synchroniser.
    assign tick = sw.f100Hz & ~f_d_reg;
    assign adv  = tick & ((state_reg == RUN) || (state_reg == LAP));

    // Ripple BCD incrementer: each digit wraps at its own maximum and passes
    // a carry up. Minutes are plain 00..99 digits; the MIN_LIMIT bound is
    // handled by the overflow compare below.
    assign carry[0] = adv;

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        localparam logic [3:0] DMAX = (gi == 3) ? 4'd5 : 4'd9;
        logic at_max;
        assign at_max = (cnt_reg[gi] == DMAX);
        assign cnt_inc[gi] = !carry[gi] ? cnt_reg[gi]
                           : (at_max ? 4'd0 : cnt_reg[gi] + 4'd1);
        if (gi < 5) begin : g_carry
            assign carry[gi+1] = carry[gi] & at_max;
        end
    end

    assign at_limit = (cnt_reg[1:0] == 8'h99) &&
                      (cnt_reg[3:2] == 8'h59) &&
                      (cnt_reg[5:4] == MIN_LIMIT_BCD);
    assign ovf_evt  = adv & at_limit;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        disp_next  = disp_reg;

        if (sw.clr) begin
            // Clear wins over everything, including a coincident tick.
            state_next = IDLE;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf_next = 1'b1;
                cnt_next = HOLD_ON_OVF ? cnt_reg : '0;
            end else begin
                cnt_next = cnt_inc;
            end

            if (ovf_evt && HOLD_ON_OVF) begin
                state_next = PAUSE;
            end else if (sw.start_stop) begin
                case (state_reg)
                    IDLE:    state_next = RUN;
                    RUN:     state_next = PAUSE;
                    PAUSE:   state_next = RUN;
                    LAP:     state_next = PAUSE;
                    default: state_next = state_reg;
                endcase
            end else if (sw.lap) begin
                case (state_reg)
                    RUN:     state_next = LAP;
                    LAP:     state_next = RUN;
                    default: state_next = state_reg;
                endcase
            end
        end

        // Display is live except while staying in LAP. Entering LAP loads the
        // count of that edge, which becomes the frozen value.
        if (!((state_reg == LAP) && (state_next == LAP))) begin
            disp_next = cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            f_d_reg        <= 1'b0;
            cnt_reg        <= '0;
            disp_reg       <= '0;
            running_reg    <= 1'b0;
            lap_active_reg <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            f_d_reg        <= sw.f100Hz;
            cnt_reg        <= cnt_next;
            disp_reg       <= disp_next;
            running_reg    <= (state_next == RUN) || (state_next == LAP);
            lap_active_reg <= (state_next == LAP);
            ovf_reg        <= ovf_next;
        end
    end

    assign sw.cs_bcd     = disp_reg[1:0];
    assign sw.sec_bcd    = disp_reg[3:2];
    assign sw.min_bcd    = disp_reg[5:4];
    assign sw.running    = running_reg;
    assign sw.lap_active = lap_active_reg;
    assign sw.ovf        = ovf_reg;

endmodule

// File: tb/tb_stopwatch_core.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_core
// Directed, table-driven bench for stopwatch_core. The main instance uses the
// default parameters; two extra instances with MIN_LIMIT=0 exercise overflow
// in hold and wrap modes within a short run.
// ---------------------------------------------------------------------------
module tb_stopwatch_core;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic f100 = 1'b0;
    logic ss = 1'b0, lp = 1'b0, cl = 1'b0;
    logic ss_o = 1'b0, cl_o = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_core_if sw_m ();
    stopwatch_core_if sw_h ();
    stopwatch_core_if sw_w ();

    assign sw_m.f100Hz = f100;
    assign sw_m.start_stop = ss;
    assign sw_m.lap = lp;
    assign sw_m.clr = cl;

    assign sw_h.f100Hz = f100;
    assign sw_h.start_stop = ss_o;
    assign sw_h.lap = 1'b0;
    assign sw_h.clr = cl_o;

    assign sw_w.f100Hz = f100;
    assign sw_w.start_stop = ss_o;
    assign sw_w.lap = 1'b0;
    assign sw_w.clr = cl_o;

    stopwatch_core dut (.clk(clk), .rst(rst), .sw(sw_m));
    stopwatch_core #(.MIN_LIMIT(0), .HOLD_ON_OVF(1'b1)) dut_hold (.clk(clk), .rst(rst), .sw(sw_h));
    stopwatch_core #(.MIN_LIMIT(0), .HOLD_ON_OVF(1'b0)) dut_wrap (.clk(clk), .rst(rst), .sw(sw_w));

    typedef struct {
        bit         ss;
        bit         lp;
        bit         cl;
        bit         tk;      // tick in the same cycle as the pulses
        int         n;       // ticks applied afterwards
        logic [7:0] e_min;
        logic [7:0] e_sec;
        logic [7:0] e_cs;
        bit         e_run;
        bit         e_lap;
        bit         e_ovf;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] cs,
                           input logic r, input logic la, input logic o,
                           input logic [7:0] e_mn, input logic [7:0] e_sc, input logic [7:0] e_cs,
                           input bit e_r, input bit e_la, input bit e_o);
        chk({tag, "_min"}, mn, e_mn);
        chk({tag, "_sec"}, sc, e_sc);
        chk({tag, "_cs"},  cs, e_cs);
        chk({tag, "_run"}, {7'd0, r},  {7'd0, e_r});
        chk({tag, "_lap"}, {7'd0, la}, {7'd0, e_la});
        chk({tag, "_ovf"}, {7'd0, o},  {7'd0, e_o});
    endtask

    task automatic chk_main(input string tag,
                            input logic [7:0] e_mn, input logic [7:0] e_sc, input logic [7:0] e_cs,
                            input bit e_r, input bit e_la, input bit e_o);
        chk_all(tag, sw_m.min_bcd, sw_m.sec_bcd, sw_m.cs_bcd,
                sw_m.running, sw_m.lap_active, sw_m.ovf,
                e_mn, e_sc, e_cs, e_r, e_la, e_o);
        $display("%s: %h:%h.%h run=%0b lap=%0b ovf=%0b", tag,
                 sw_m.min_bcd, sw_m.sec_bcd, sw_m.cs_bcd,
                 sw_m.running, sw_m.lap_active, sw_m.ovf);
    endtask

    // One 100 Hz period compressed to two clocks: high then low.
    task automatic tick();
        f100 = 1'b1;
        @(posedge clk); #1;
        f100 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        vecs[0]  = '{Y, N, N, N, 150,  8'h00, 8'h01, 8'h50, Y, N, N};
        vecs[1]  = '{N, N, N, N, 80,   8'h00, 8'h02, 8'h30, Y, N, N};
        vecs[2]  = '{N, Y, N, N, 70,   8'h00, 8'h02, 8'h30, Y, Y, N};
        vecs[3]  = '{N, Y, N, N, 0,    8'h00, 8'h03, 8'h00, Y, N, N};
        vecs[4]  = '{N, N, N, N, 212,  8'h00, 8'h05, 8'h12, Y, N, N};
        vecs[5]  = '{Y, N, Y, N, 0,    8'h00, 8'h00, 8'h00, N, N, N};
        vecs[6]  = '{Y, N, N, N, 9,    8'h00, 8'h00, 8'h09, Y, N, N};
        vecs[7]  = '{Y, N, N, Y, 50,   8'h00, 8'h00, 8'h10, N, N, N};
        vecs[8]  = '{Y, N, N, N, 5,    8'h00, 8'h00, 8'h15, Y, N, N};
        vecs[9]  = '{N, Y, N, Y, 10,   8'h00, 8'h00, 8'h16, Y, Y, N};
        vecs[10] = '{Y, N, N, N, 3,    8'h00, 8'h00, 8'h26, N, N, N};
        vecs[11] = '{N, Y, N, N, 4,    8'h00, 8'h00, 8'h26, N, N, N};
        vecs[12] = '{Y, N, N, N, 0,    8'h00, 8'h00, 8'h26, Y, N, N};
        vecs[13] = '{N, N, Y, Y, 0,    8'h00, 8'h00, 8'h00, N, N, N};
        vecs[14] = '{N, Y, N, N, 3,    8'h00, 8'h00, 8'h00, N, N, N};
        vecs[15] = '{Y, N, N, N, 6123, 8'h01, 8'h01, 8'h23, Y, N, N};
        vecs[16] = '{N, Y, N, N, 0,    8'h01, 8'h01, 8'h23, Y, Y, N};
        vecs[17] = '{N, N, Y, N, 0,    8'h00, 8'h00, 8'h00, N, N, N};

        // Reset with the divider output toggling.
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            f100 = ~f100;
            @(posedge clk); #1;
        end
        f100 = 1'b0;
        rst  = 1'b0;
        @(posedge clk); #1;
        chk_main("reset", 8'h00, 8'h00, 8'h00, N, N, N);
        ticks(5);
        chk_main("idle_ticks", 8'h00, 8'h00, 8'h00, N, N, N);

        for (int i = 0; i < 18; i++) begin
            ss   = vecs[i].ss;
            lp   = vecs[i].lp;
            cl   = vecs[i].cl;
            f100 = vecs[i].tk;
            @(posedge clk); #1;
            ss = 1'b0; lp = 1'b0; cl = 1'b0; f100 = 1'b0;
            @(posedge clk); #1;
            ticks(vecs[i].n);
            chk_main($sformatf("v%0d", i), vecs[i].e_min, vecs[i].e_sec, vecs[i].e_cs,
                     vecs[i].e_run, vecs[i].e_lap, vecs[i].e_ovf);
        end

        // Overflow: MIN_LIMIT=0, so the last count is 00:59.99.
        ss_o = 1'b1;
        @(posedge clk); #1;
        ss_o = 1'b0;
        @(posedge clk); #1;
        ticks(5998);
        chk_all("hold_5998", sw_h.min_bcd, sw_h.sec_bcd, sw_h.cs_bcd, sw_h.running, sw_h.lap_active, sw_h.ovf,
                8'h00, 8'h59, 8'h98, Y, N, N);
        chk_all("wrap_5998", sw_w.min_bcd, sw_w.sec_bcd, sw_w.cs_bcd, sw_w.running, sw_w.lap_active, sw_w.ovf,
                8'h00, 8'h59, 8'h98, Y, N, N);
        ticks(1);
        chk_all("hold_last", sw_h.min_bcd, sw_h.sec_bcd, sw_h.cs_bcd, sw_h.running, sw_h.lap_active, sw_h.ovf,
                8'h00, 8'h59, 8'h99, Y, N, N);
        chk_all("wrap_last", sw_w.min_bcd, sw_w.sec_bcd, sw_w.cs_bcd, sw_w.running, sw_w.lap_active, sw_w.ovf,
                8'h00, 8'h59, 8'h99, Y, N, N);
        ticks(1);
        chk_all("hold_ovf", sw_h.min_bcd, sw_h.sec_bcd, sw_h.cs_bcd, sw_h.running, sw_h.lap_active, sw_h.ovf,
                8'h00, 8'h59, 8'h99, N, N, Y);
        chk_all("wrap_ovf", sw_w.min_bcd, sw_w.sec_bcd, sw_w.cs_bcd, sw_w.running, sw_w.lap_active, sw_w.ovf,
                8'h00, 8'h00, 8'h00, Y, N, Y);
        $display("overflow: hold %h:%h.%h ovf=%0b, wrap %h:%h.%h ovf=%0b",
                 sw_h.min_bcd, sw_h.sec_bcd, sw_h.cs_bcd, sw_h.ovf,
                 sw_w.min_bcd, sw_w.sec_bcd, sw_w.cs_bcd, sw_w.ovf);
        ticks(1);
        chk_all("hold_after", sw_h.min_bcd, sw_h.sec_bcd, sw_h.cs_bcd, sw_h.running, sw_h.lap_active, sw_h.ovf,
                8'h00, 8'h59, 8'h99, N, N, Y);
        chk_all("wrap_after", sw_w.min_bcd, sw_w.sec_bcd, sw_w.cs_bcd, sw_w.running, sw_w.lap_active, sw_w.ovf,
                8'h00, 8'h00, 8'h01, Y, N, Y);
        cl_o = 1'b1;
        @(posedge clk); #1;
        cl_o = 1'b0;
        @(posedge clk); #1;
        chk_all("hold_clr", sw_h.min_bcd, sw_h.sec_bcd, sw_h.cs_bcd, sw_h.running, sw_h.lap_active, sw_h.ovf,
                8'h00, 8'h00, 8'h00, N, N, N);
        chk_all("wrap_clr", sw_w.min_bcd, sw_w.sec_bcd, sw_w.cs_bcd, sw_w.running, sw_w.lap_active, sw_w.ovf,
                8'h00, 8'h00, 8'h00, N, N, N);
        $display("overflow clr: hold ovf=%0b, wrap ovf=%0b", sw_h.ovf, sw_w.ovf);

        // Reset in the middle of a run with a pending start_stop pulse.
        ss = 1'b1;
        @(posedge clk); #1;
        ss = 1'b0;
        ticks(37);
        chk_main("pre_rst", 8'h00, 8'h00, 8'h37, Y, N, N);
        rst = 1'b1;
        ss  = 1'b1;
        f100 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ss  = 1'b0;
        f100 = 1'b0;
        chk_main("mid_rst", 8'h00, 8'h00, 8'h00, N, N, N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
